// File: rtl/ball_tx_packer_if.sv
// ball_tx_packer_if: byte-stream handshake carrying packed ball packets to the I2C transmit path
interface ball_tx_packer_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;
  modport master (output tx_byte, tx_valid, tx_last, input tx_ready);
  modport slave (input tx_byte, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/ball_tx_packer.sv
// ball_tx_packer: snapshots ball state on a trigger edge and streams a 9-byte checksummed packet
module ball_tx_packer #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         GAP_CYC     = 64,
  parameter int         TIMEOUT_CYC = 25000
) (
  input  logic             clk_25MHZ,
  input  logic             reset,
  input  logic             ball_send_trigger,
  input  logic [9:0]       ball_y_out,
  input  logic [7:0]       ball_vy,
  input  logic [1:0]       gravity_counter,
  input  logic [7:0]       ball_speed_reg0,
  input  logic [7:0]       ball_speed_reg1,
  input  logic [3:0]       ball_speed_reg2,
  ball_tx_packer_if.master tx,
  output logic             busy,
  output logic             abort_pulse,
  output logic [7:0]       drop_count
);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t          state;
  logic            trig_prev, armed, trig_evt, xfer;
  logic [9:0]      y_q;
  logic [7:0]      vy_q, s0_q, s1_q, csum;
  logic [1:0]      g_q;
  logic [3:0]      s2_q, idx, nidx;
  logic [GW-1:0]   gap_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [7:0]      pb [9];
  // armed stays low after reset until the trigger is seen low, so a held trigger cannot fire
  assign trig_evt = ball_send_trigger & ~trig_prev & armed;
  assign xfer     = tx.tx_valid & tx.tx_ready;
  assign busy     = state != IDLE;
  assign nidx     = idx + 4'd1;
  assign csum     = HEADER ^ y_q[7:0] ^ {6'b0, y_q[9:8]} ^ vy_q ^ {6'b0, g_q} ^ s0_q ^ s1_q ^ {4'b0, s2_q};
  always_comb begin
    pb[0] = HEADER;
    pb[1] = y_q[7:0];
    pb[2] = {6'b0, y_q[9:8]};
    pb[3] = vy_q;
    pb[4] = {6'b0, g_q};
    pb[5] = s0_q;
    pb[6] = s1_q;
    pb[7] = {4'b0, s2_q};
    pb[8] = csum;
  end
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      trig_prev   <= 1'b0;
      armed       <= 1'b0;
      y_q         <= '0;
      vy_q        <= '0;
      g_q         <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      idx         <= '0;
      gap_cnt     <= '0;
      wait_cnt    <= '0;
      tx.tx_byte  <= 8'h00;
      tx.tx_valid <= 1'b0;
      tx.tx_last  <= 1'b0;
      abort_pulse <= 1'b0;
      drop_count  <= 8'h00;
    end else begin
      trig_prev   <= ball_send_trigger;
      armed       <= armed | ~ball_send_trigger;
      abort_pulse <= 1'b0;
      if (trig_evt && state != IDLE && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      case (state)
        IDLE: if (trig_evt) begin
          y_q         <= ball_y_out;
          vy_q        <= ball_vy;
          g_q         <= gravity_counter;
          s0_q        <= ball_speed_reg0;
          s1_q        <= ball_speed_reg1;
          s2_q        <= ball_speed_reg2;
          idx         <= '0;
          wait_cnt    <= '0;
          tx.tx_byte  <= HEADER;
          tx.tx_valid <= 1'b1;
          tx.tx_last  <= 1'b0;
          state       <= SEND;
        end
        SEND: if (xfer) begin
          wait_cnt <= '0;
          if (idx == 4'd8) begin
            idx         <= '0;
            tx.tx_byte  <= 8'h00;
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
            gap_cnt     <= GW'(GAP_CYC);
            state       <= GAP;
          end else begin
            idx        <= nidx;
            tx.tx_byte <= pb[nidx];
            tx.tx_last <= idx == 4'd7;
          end
        end else if (wait_cnt == WW'(TIMEOUT_CYC - 1)) begin
          abort_pulse <= 1'b1;
          idx         <= '0;
          wait_cnt    <= '0;
          tx.tx_byte  <= 8'h00;
          tx.tx_valid <= 1'b0;
          tx.tx_last  <= 1'b0;
          gap_cnt     <= GW'(GAP_CYC);
          state       <= GAP;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == GW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ball_tx_packer.sv
// tb_ball_tx_packer: scoreboard bench; stimulus queues expected bytes, a negedge monitor pops and compares
module tb_ball_tx_packer;
  logic       clk = 1'b0, rst = 1'b1, trig = 1'b0;
  logic [9:0] y = '0;
  logic [7:0] vy = '0, s0 = '0, s1 = '0, drops;
  logic [1:0] g = '0;
  logic [3:0] s2 = '0;
  logic       busy, abort_p;
  int         errors = 0, checks = 0, nacc = 0, bc, vc, n;
  bit         chk_en = 1'b1, prev_stall = 1'b0;
  logic [8:0] prev_out, exp_out;
  logic [8:0] sb [$];
  logic [7:0] v1 [9] = '{8'hA5, 8'hF3, 8'h01, 8'hFD, 8'h02, 8'h12, 8'h34, 8'h05, 8'h8B};
  logic [7:0] v2 [9] = '{8'hA5, 8'hC7, 8'h02, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h0A, 8'h14};
  ball_tx_packer_if txi ();
  ball_tx_packer #(.HEADER(8'hA5), .GAP_CYC(64), .TIMEOUT_CYC(100)) dut (
    .clk_25MHZ(clk), .reset(rst), .ball_send_trigger(trig), .ball_y_out(y), .ball_vy(vy),
    .gravity_counter(g), .ball_speed_reg0(s0), .ball_speed_reg1(s1), .ball_speed_reg2(s2),
    .tx(txi), .busy(busy), .abort_pulse(abort_p), .drop_count(drops)
  );
  always #20 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_exp(input bit second, input int cnt);
    for (int i = 0; i < cnt; i++) sb.push_back({i == 8, second ? v2[i] : v1[i]});
  endtask
  task automatic set_vec(input bit second);
    y  = second ? 10'h2C7 : 10'h1F3;
    vy = second ? 8'h80 : 8'hFD;
    g  = second ? 2'd1 : 2'd2;
    s0 = second ? 8'hFF : 8'h12;
    s1 = second ? 8'h00 : 8'h34;
    s2 = second ? 4'hA : 4'h5;
  endtask
  task automatic pulse_trigger;
    @(posedge clk); #1 trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
  endtask
  task automatic wait_idle(output int b, output int v);
    b = 0;
    v = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) return;
      b++;
      v += int'(txi.tx_valid);
    end
    chk("idle_timeout", 1, 0);
  endtask
  initial forever begin
    @(negedge clk);
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall && txi.tx_valid) chk("stall_stable", int'({txi.tx_last, txi.tx_byte}), int'(prev_out));
      if (chk_en && txi.tx_valid && txi.tx_ready) begin
        if (sb.size() == 0) chk("unexpected_byte", int'({txi.tx_last, txi.tx_byte}), 9'h1FF);
        else begin
          exp_out = sb.pop_front();
          chk("pkt_byte", int'({txi.tx_last, txi.tx_byte}), int'(exp_out));
        end
        nacc++;
      end
      prev_stall = txi.tx_valid && !txi.tx_ready;
      prev_out = {txi.tx_last, txi.tx_byte};
    end
  end
  initial begin
    txi.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(txi.tx_valid), 0);
    chk("rst_byte", int'(txi.tx_byte), 0);
    chk("rst_last", int'(txi.tx_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_abort", int'(abort_p), 0);
    chk("rst_drops", int'(drops), 0);
    @(posedge clk); #1 rst = 1'b0;
    set_vec(1'b0);
    txi.tx_ready = 1'b1;
    nacc = 0;
    push_exp(1'b0, 9);
    pulse_trigger();
    wait_idle(bc, vc);
    chk("a_busy_cycles", bc, 73);
    chk("a_valid_cycles", vc, 9);
    chk("a_accepted", nacc, 9);
    chk("a_sb_empty", sb.size(), 0);
    nacc = 0;
    push_exp(1'b0, 9);
    pulse_trigger();
    fork
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1 txi.tx_ready = (i % 4 == 0) || (i % 4 == 3);
      end
      wait_idle(bc, vc);
    join
    txi.tx_ready = 1'b1;
    chk("b_accepted", nacc, 9);
    chk("b_sb_empty", sb.size(), 0);
    chk("b_stalls_seen", int'(vc > 9), 1);
    nacc = 0;
    push_exp(1'b0, 9);
    pulse_trigger();
    pulse_trigger();
    repeat (10) @(posedge clk);
    pulse_trigger();
    wait_idle(bc, vc);
    chk("c_drops_two", int'(drops), 2);
    chk("c_accepted", nacc, 9);
    chk_en = 1'b0;
    for (int i = 0; i < 300; i++) pulse_trigger();
    wait_idle(bc, vc);
    chk_en = 1'b1;
    sb.delete();
    chk("c_drops_sat", int'(drops), 255);
    nacc = 0;
    push_exp(1'b0, 1);
    pulse_trigger();
    @(posedge clk); #1 txi.tx_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!txi.tx_valid) break;
      n++;
    end
    chk("d_stall_cycles", n, 100);
    chk("d_abort_high", int'(abort_p), 1);
    chk("d_busy_gap", int'(busy), 1);
    @(negedge clk);
    chk("d_abort_once", int'(abort_p), 0);
    wait_idle(bc, vc);
    chk("d_accepted", nacc, 1);
    txi.tx_ready = 1'b1;
    nacc = 0;
    push_exp(1'b0, 9);
    pulse_trigger();
    wait_idle(bc, vc);
    chk("d_retry_accepted", nacc, 9);
    chk("d_retry_sb_empty", sb.size(), 0);
    nacc = 0;
    push_exp(1'b0, 5);
    pulse_trigger();
    repeat (5) @(posedge clk);
    #1 txi.tx_ready = 1'b0;
    trig = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("e_async_valid", int'(txi.tx_valid), 0);
    chk("e_async_busy", int'(busy), 0);
    chk("e_async_drops", int'(drops), 0);
    chk("e_accepted", nacc, 5);
    chk("e_sb_empty", sb.size(), 0);
    @(posedge clk); #1 rst = 1'b0;
    txi.tx_ready = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(busy);
    end
    chk("e_held_no_start", n, 0);
    @(posedge clk); #1 trig = 1'b0;
    nacc = 0;
    push_exp(1'b0, 9);
    pulse_trigger();
    wait_idle(bc, vc);
    chk("e_new_edge_accepted", nacc, 9);
    set_vec(1'b1);
    nacc = 0;
    push_exp(1'b1, 9);
    pulse_trigger();
    fork
      for (int i = 0; i < 12; i++) begin
        #2;
        y = 10'($urandom);
        vy = 8'($urandom);
        g = 2'($urandom);
        s0 = 8'($urandom);
        s1 = 8'($urandom);
        s2 = 4'($urandom);
        @(posedge clk);
      end
      wait_idle(bc, vc);
    join
    chk("f_accepted", nacc, 9);
    chk("f_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ball_tx_packer.md
BALL_TX_PACKER -- requirements
Module: ball_tx_packer

Interface
REQ-001 Parameter HEADER, default 8'hA5, first byte of every packet.
REQ-002 Parameter GAP_CYC, default 64, idle cycles enforced after each packet before the next may start.
REQ-003 Parameter TIMEOUT_CYC, default 25000, maximum consecutive cycles tx_valid may wait for tx_ready before the packet is aborted.
REQ-004 clk_25MHZ  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ball_send_trigger  input  1  request to send current ball state to the opponent board.
REQ-007 ball_y_out  input  10  ball y position.
REQ-008 ball_vy  input  8  signed ball y velocity.
REQ-009 gravity_counter  input  2  gravity phase.
REQ-010 ball_speed_reg0 / ball_speed_reg1  input  8 each  ball speed bytes 0 and 1.
REQ-011 ball_speed_reg2  input  4  ball speed nibble 2.
REQ-012 tx_byte  output  8  packet byte presented to the I2C transmit path.
REQ-013 tx_valid  output  1  tx_byte is valid.
REQ-014 tx_ready  input  1  downstream accepts tx_byte this cycle.
REQ-015 tx_last  output  1  high with the final (checksum) byte.
REQ-016 busy  output  1  high whenever not in IDLE.
REQ-017 abort_pulse  output  1  one-cycle pulse on timeout abort.
REQ-018 drop_count  output  8  saturating count of ignored trigger edges.

Function
REQ-019 States: IDLE, SEND, GAP; each stored as a registered state variable.
REQ-020 A trigger event is a rising edge of ball_send_trigger (high now, low in previous cycle, previous-value register reset to 0).
REQ-021 In IDLE, a trigger event in cycle N snapshots all ball inputs into internal registers and enters SEND; tx_valid=1 with tx_byte=HEADER from cycle N+1.
REQ-022 Packet byte order, 9 bytes: HEADER; ball_y[7:0]; {6'b0, ball_y[9:8]}; ball_vy; {6'b0, gravity_counter}; speed_reg0; speed_reg1; {4'b0, speed_reg2}; checksum.
REQ-023 Checksum = bitwise XOR of bytes 0..7, computed from the snapshot only.
REQ-024 A byte is transferred in any cycle with tx_valid and tx_ready both high; the next byte appears the following cycle, back-to-back at one byte per cycle when tx_ready stays high.
REQ-025 tx_byte, tx_last must remain stable while tx_valid=1 and tx_ready=0.
REQ-026 tx_last=1 only while the checksum byte is presented.
REQ-027 On checksum acceptance: tx_valid=0 next cycle, enter GAP, load gap counter with GAP_CYC.
REQ-028 GAP counts down one per cycle; returns to IDLE after exactly GAP_CYC cycles; busy remains 1 throughout.
REQ-029 Wait counter: cleared on every accepted byte, incremented each cycle tx_valid=1 and tx_ready=0; at TIMEOUT_CYC it forces tx_valid=0, pulses abort_pulse for one cycle, enters GAP.
REQ-030 A trigger event while in SEND or GAP (including the cycle of checksum acceptance) is ignored and increments drop_count, saturating at 255.
REQ-031 Ball inputs changing during SEND do not affect the packet in flight.
REQ-032 Snapshot and byte-index registers must not wrap: byte index ranges 0..8 only.

Reset
REQ-033 While reset=1, and immediately on its assertion mid-packet: state=IDLE, tx_valid=0, tx_last=0, tx_byte=8'h00, busy=0, abort_pulse=0, drop_count=0, all counters and snapshots 0.
REQ-034 A trigger held high through reset release does not start a packet; a new rising edge is required.

Verification
REQ-035 y=10'h1F3, vy=8'hFD, g=2, s0=8'h12, s1=8'h34, s2=4'h5, tx_ready=1, trigger pulse -> bytes A5,F3,01,FD,02,12,34,05,8B on 9 consecutive cycles, tx_last only on 8B, then busy for 64 cycles.
REQ-036 Same packet, tx_ready toggled 1,0,0,1 repeating -> identical byte sequence, each byte stable across stalls, no byte duplicated or skipped.
REQ-037 Second trigger edge during SEND and another during GAP -> drop_count=2, only one packet emitted; 300 extra edges while busy -> drop_count=255.
REQ-038 TIMEOUT_CYC=100, tx_ready=0 after header accepted -> tx_valid falls after 100 stall cycles, abort_pulse one cycle, GAP then IDLE; next trigger sends a full packet from HEADER.
REQ-039 Reset asserted after byte 4 accepted -> tx_valid=0 asynchronously; after release with trigger held high, no packet until trigger falls and rises again.
REQ-040 Ball inputs changed every cycle during SEND -> packet bytes match the values sampled at the trigger edge.
